// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - instruction sequencer feeding an external combinational ALU
// Owns a small register file; one instruction in flight, results written back in WRITEBACK.
module alu_operand_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int REGISTER_WIDTH = 8,
  parameter int REG_ADDR_WIDTH = 2,
  parameter logic [OPCODE_WIDTH-1:0] LOADI1 = 4'd1
) (
  input  logic                                                    clock,
  input  logic                                                    resetN,
  input  logic                                                    instrValid,
  output logic                                                    instrReady,
  input  logic [OPCODE_WIDTH+3*REG_ADDR_WIDTH+REGISTER_WIDTH-1:0] instrWord,
  output logic [OPCODE_WIDTH-1:0]                                 aluOpCode,
  output logic [REGISTER_WIDTH-1:0]                               aluOperand1,
  output logic [REGISTER_WIDTH-1:0]                               aluOperand2,
  input  logic [REGISTER_WIDTH-1:0]                               aluResult,
  output logic                                                    done,
  output logic [REGISTER_WIDTH-1:0]                               resultValue,
  output logic                                                    resultZero,
  input  logic [REG_ADDR_WIDTH-1:0]                               readAddress,
  output logic [REGISTER_WIDTH-1:0]                               readData
);

  localparam int INSTR_WIDTH = OPCODE_WIDTH + 3*REG_ADDR_WIDTH + REGISTER_WIDTH;
  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, EXECUTE, WRITEBACK} state_t;

  state_t                    state;
  logic [REGISTER_WIDTH-1:0] regFile [NUM_REGS];
  logic [OPCODE_WIDTH-1:0]   opQ;
  logic [REG_ADDR_WIDTH-1:0] destQ;
  logic [REG_ADDR_WIDTH-1:0] src1Q;
  logic [REG_ADDR_WIDTH-1:0] src2Q;
  logic [REGISTER_WIDTH-1:0] resultReg;

  logic [OPCODE_WIDTH-1:0]   inOp;
  logic [REG_ADDR_WIDTH-1:0] inDest;
  logic [REG_ADDR_WIDTH-1:0] inSrc1;
  logic [REG_ADDR_WIDTH-1:0] inSrc2;
  logic [REGISTER_WIDTH-1:0] inImm;

  assign inOp   = instrWord[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign inDest = instrWord[REGISTER_WIDTH+3*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign inSrc1 = instrWord[REGISTER_WIDTH+2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign inSrc2 = instrWord[REGISTER_WIDTH+REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign inImm  = instrWord[REGISTER_WIDTH-1:0];

  // Debug port sees the register file as-is; writes land at the end of WRITEBACK.
  assign readData = regFile[readAddress];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
      opQ         <= '0;
      destQ       <= '0;
      src1Q       <= '0;
      src2Q       <= '0;
      resultReg   <= '0;
      aluOpCode   <= '0;
      aluOperand1 <= '0;
      aluOperand2 <= '0;
      instrReady  <= 1'b1;
      done        <= 1'b0;
      resultValue <= '0;
      resultZero  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (instrValid) begin
            opQ        <= inOp;
            destQ      <= inDest;
            src1Q      <= inSrc1;
            src2Q      <= inSrc2;
            instrReady <= 1'b0;
            // Load-immediate bypasses the ALU and goes straight to writeback.
            if (inOp == LOADI1) begin
              resultReg <= inImm;
              done      <= 1'b1;
              state     <= WRITEBACK;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          aluOpCode   <= opQ;
          aluOperand1 <= regFile[src1Q];
          aluOperand2 <= regFile[src2Q];
          state       <= EXECUTE;
        end
        EXECUTE: begin
          resultReg <= aluResult;
          done      <= 1'b1;
          state     <= WRITEBACK;
        end
        WRITEBACK: begin
          regFile[destQ] <= resultReg;
          resultValue    <= resultReg;
          resultZero     <= (resultReg == '0);
          done           <= 1'b0;
          instrReady     <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
